// File: rtl/llnn_infer_seq.sv
// Sequencer between the register block and the LLNN core: snapshots the image on start,
// waits the core latency, and queues {class, tag} results in a small FWFT FIFO.
module llnn_infer_seq #(
  parameter int NET_INPUTS  = 400,
  parameter int NET_OUTPUTS = 4,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NET_INPUTS-1:0]         in_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          err_start,
  input  logic                          clr_err,
  output logic [NET_INPUTS-1:0]         core_i,
  input  logic [NET_OUTPUTS-1:0]        core_o,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [NET_OUTPUTS-1:0]        res_class,
  output logic [TAG_W-1:0]              res_tag,
  output logic [$clog2(FIFO_DEPTH):0]   res_count,
  output logic [31:0]                   infer_cnt
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          wcnt;
  logic [TAG_W-1:0]       tag_cnt, cur_tag;
  logic [NET_OUTPUTS-1:0] cls_mem [FIFO_DEPTH];
  logic [TAG_W-1:0]       tag_mem [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [NW-1:0]          cnt_after_pop;
  logic [NET_OUTPUTS-1:0] head_cls_nxt;
  logic [TAG_W-1:0]       head_tag_nxt;
  logic                   accept, push, pop, full, push_ok;

  assign res_valid = (res_count != NW'(0));
  assign full      = (res_count == NW'(FIFO_DEPTH));
  assign pop       = res_valid && res_ready;
  assign push_ok   = !full || pop;
  assign busy      = (state != S_IDLE);

  // next-state logic: a start is only accepted from IDLE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wcnt == CW'(0)) begin
          if (push_ok) begin
            push      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_HOLD;
          end
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (push_ok) begin
          push      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_HOLD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // control state, snapshot, tags, error flag and completion counter
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= S_IDLE;
      core_i    <= '0;
      wcnt      <= '0;
      tag_cnt   <= '0;
      cur_tag   <= '0;
      err_start <= 1'b0;
      infer_cnt <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        core_i  <= in_data;
        cur_tag <= tag_cnt;
        tag_cnt <= tag_cnt + TAG_W'(1);
        wcnt    <= CW'(LATENCY - 1);
      end else if (state == S_WAIT && wcnt != CW'(0)) begin
        wcnt <= wcnt - CW'(1);
      end
      if (push) infer_cnt <= infer_cnt + 32'd1;
      if (start && state != S_IDLE) err_start <= 1'b1;
      else if (clr_err)             err_start <= 1'b0;
    end
  end

  // head after this edge: a push into an otherwise-empty FIFO bypasses the storage
  always_comb begin
    cnt_after_pop = res_count - (pop ? NW'(1) : NW'(0));
    rd_ptr_nxt    = pop ? rd_ptr + PW'(1) : rd_ptr;
    head_cls_nxt  = res_class;
    head_tag_nxt  = res_tag;
    if (push && cnt_after_pop == NW'(0)) begin
      head_cls_nxt = core_o;
      head_tag_nxt = cur_tag;
    end else if (cnt_after_pop != NW'(0)) begin
      head_cls_nxt = cls_mem[rd_ptr_nxt];
      head_tag_nxt = tag_mem[rd_ptr_nxt];
    end else begin
      head_cls_nxt = res_class;
      head_tag_nxt = res_tag;
    end
  end

  // result storage
  always_ff @(posedge ACLK) begin
    if (push) begin
      cls_mem[wr_ptr] <= core_o;
      tag_mem[wr_ptr] <= cur_tag;
    end
  end

  // FIFO pointers, occupancy and registered head
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      res_count <= '0;
      res_class <= '0;
      res_tag   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr    <= rd_ptr_nxt;
      res_count <= cnt_after_pop + (push ? NW'(1) : NW'(0));
      res_class <= head_cls_nxt;
      res_tag   <= head_tag_nxt;
    end
  end
endmodule

// File: doc/llnn_infer_seq.md
Name: llnn_infer_seq

Overview:
- Sequencing stage between the AXI-Lite input/output register block and the hardened LLNN core.
- On a start pulse it snapshots the 400-bit input image into a stable holding register that drives the core, so partial AXI word updates never reach the network mid-inference.
- It waits the core's fixed pipeline latency, captures the classification, and pushes it with a sequence tag into a small first-word-fall-through (FWFT) result FIFO for software to drain.

Parameters:
- NET_INPUTS, 400, width of the input image / core input.
- NET_OUTPUTS, 4, width of the core classification output.
- LATENCY, 2, cycles from core_i change to valid core_o; must be ≥1 (a combinational core uses 1).
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥2.
- TAG_W, 8, sequence-tag width.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- in_data  in  NET_INPUTS  image from the register block (may change any cycle).
- start  in  1  single-cycle request to run one inference on current in_data.
- busy  out  1  high while an inference is in flight or stalled.
- err_start  out  1  sticky: start seen while busy (start dropped).
- clr_err  in  1  clears err_start.
- core_i  out  NET_INPUTS  registered snapshot driving the LLNN core.
- core_o  in  NET_OUTPUTS  LLNN core classification.
- res_valid  out  1  FIFO non-empty.
- res_ready  in  1  consumer pop.
- res_class  out  NET_OUTPUTS  head-entry classification.
- res_tag  out  TAG_W  head-entry tag.
- res_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- infer_cnt  out  32  completed (pushed) inferences, wraps 2^32-1 → 0.

Behaviour:
- Reset (ARESET high at an edge): state IDLE, core_i=0, busy=0, err_start=0, FIFO empty (res_valid=0, res_count=0, res_class=0, res_tag=0), tag counter=0, infer_cnt=0, wait counter=0. Reset mid-inference or mid-stall aborts with no push.
- FSM states: IDLE, WAIT, HOLD.
- IDLE: start=1 at edge k → core_i<=in_data, cur_tag<=tag counter, tag counter++ (wraps mod 2^TAG_W), wait counter<=LATENCY-1, state WAIT, busy=1 after edge k.
- WAIT: while the counter is nonzero, decrement it. At the edge with counter==0 (edge k+LATENCY), sample core_o. If FIFO not full or a pop occurs the same cycle, push {core_o, cur_tag}, infer_cnt++, go IDLE, and busy falls after that edge. Otherwise go HOLD.
- HOLD: core_i held; each edge re-evaluate the push condition (not full or pop this cycle); on push go IDLE. core_o is sampled at the push edge.
- start while busy (WAIT/HOLD) or in the same cycle the FSM leaves WAIT/HOLD: dropped, err_start<=1, no tag increment.
  - start in the IDLE cycle directly after a completion is accepted.
  - Throughput: one inference per LATENCY+1 cycles.
- clr_err=1 clears err_start; simultaneous clr_err and a new error → err_start=1 (set wins).
- core_i changes only on accepted start edges; in_data changes otherwise have no effect.
- FIFO: FWFT. res_class/res_tag show the head whenever res_valid=1 and hold their last value when empty.
  - Pop when res_valid && res_ready; pop on empty is ignored.
  - Push and pop in the same cycle: occupancy unchanged, including when full.
  - Pointers wrap mod FIFO_DEPTH.
  - res_count is updated at the same edge as the push/pop.
- No combinational path from any input to any output except none; all outputs registered or derived from registers (res_valid = res_count!=0).

Test Plan:
- Reset then single start with in_data=400'h…A5, core model LATENCY=2 returning 4'h7 → core_i=in_data one edge after start, busy high 2 cycles, res_valid=1 with res_class=7, res_tag=0, infer_cnt=1.
- Start held for one cycle while in_data toggles every cycle during WAIT → core_i stays at the value sampled on the start edge; captured class matches that snapshot.
- Five back-to-back inferences with res_ready=0, FIFO_DEPTH=4 → first four pushed (tags 0–3, res_count=4), fifth sits in HOLD with busy=1; assert res_ready one cycle → fifth pushed at that edge (tag 4), res_count stays 4, busy falls.
- Start pulsed during WAIT → err_start=1, no extra push, next tag unaffected; clr_err → err_start=0; clr_err concurrent with another bad start → err_start stays 1.
- Tag wrap: run 257 inferences with TAG_W=8, draining continuously → tags 0..255 then 0; infer_cnt=257.
- ARESET asserted during HOLD with FIFO full → next cycle res_valid=0, res_count=0, busy=0, core_i=0, infer_cnt=0; a subsequent start yields tag 0.
